// File: rtl/counter_arb_pkg.sv
// Shared types and constants for the two-requester counter arbiter.
package counter_arb_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_arbiter_2req_sync_2ff.sv
// Single-bit two-flop synchronizer, both stages cleared by synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/counter_arbiter_2req.sv
// Round-robin arbiter handing one shared up-counter to two requesters.
// Define COUNTER_ARB_SYNC_EN to pass req1 through a 2-flop synchronizer.
module counter_arbiter_2req
    import counter_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk0,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] limit0,
    input  logic [WIDTH-1:0] limit1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    logic req1_eff;

`ifdef COUNTER_ARB_SYNC_EN
    sync_2ff u_req1_sync (
        .clk (clk0),
        .rst (rst),
        .d   (req1),
        .q   (req1_eff)
    );
`else
    assign req1_eff = req1;
`endif

    state_t           state;
    logic             owner;   // requester currently holding the counter
    logic             ptr;     // 0 favours req0 on a tie, 1 favours req1
    logic [WIDTH-1:0] lim_l;

    logic owner_req_c;
    logic pick_c;

    assign owner_req_c = owner ? req1_eff : req0;
    assign pick_c      = (req0 && req1_eff) ? ptr : ~req0;

    always_ff @(posedge clk0) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr   <= 1'b0;
            lim_l <= '0;
            q     <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1_eff) begin
                        owner <= pick_c;
                        gnt0  <= ~pick_c;
                        gnt1  <= pick_c;
                        lim_l <= pick_c ? limit1 : limit0;
                        q     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Owner withdrawing its request aborts without a done pulse.
                    if (!owner_req_c) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        busy  <= 1'b0;
                        ptr   <= ~owner;
                        state <= IDLE;
                    end else if (q == lim_l) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= DONE;
                    end else begin
                        q <= q + WIDTH'(1);
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    ptr   <= ~owner;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter_2req.sv
// Self-checking bench for counter_arbiter_2req: directed table, corner sequences, random vs model.
module tb_counter_arbiter_2req;

    localparam int unsigned WIDTH = 4;
`ifdef COUNTER_ARB_SYNC_EN
    localparam int REQ1_LAT = 3;
`else
    localparam int REQ1_LAT = 1;
`endif

    logic             clk0 = 1'b0;
    logic             rst = 1'b0;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] limit0 = '0;
    logic [WIDTH-1:0] limit1 = '0;
    logic             gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0] q;

    int checks = 0;
    int errors = 0;

    counter_arbiter_2req #(.WIDTH(WIDTH)) dut (
        .clk0   (clk0),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .limit0 (limit0),
        .limit1 (limit1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .q      (q),
        .busy   (busy)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: one transaction = who, latched limit, elapsed cycles.
    bit m_active, m_donecyc, m_who, m_fav;
    int m_elapsed, m_lim;
`ifdef COUNTER_ARB_SYNC_EN
    logic [1:0] m_r1h = 2'b00;
`endif

    function automatic void model_step();
        bit r1e;
`ifdef COUNTER_ARB_SYNC_EN
        r1e = m_r1h[1];
        m_r1h = rst ? 2'b00 : {m_r1h[0], req1};
`else
        r1e = req1;
`endif
        if (rst) begin
            m_active  = 0;
            m_donecyc = 0;
            m_fav     = 0;
            m_elapsed = 0;
        end else if (m_active) begin
            if (!(m_who ? r1e : req0)) begin
                m_active = 0;
                m_fav    = !m_who;
            end else if (m_elapsed == m_lim) begin
                m_active  = 0;
                m_donecyc = 1;
            end else begin
                m_elapsed++;
            end
        end else if (m_donecyc) begin
            m_donecyc = 0;
            m_fav     = !m_who;
        end else if (req0 || r1e) begin
            m_who     = (req0 && r1e) ? m_fav : !req0;
            m_lim     = m_who ? int'(limit1) : int'(limit0);
            m_elapsed = 0;
            m_active  = 1;
        end
    endfunction

    function automatic logic [8:0] model_out();
        return {m_active & !m_who, m_active & m_who, m_donecyc & !m_who,
                m_donecyc & m_who, m_active | m_donecyc, 4'(m_elapsed)};
    endfunction

    task automatic tick(input string nm);
        model_step();
        @(posedge clk0);
        #1;
        chk(nm, 16'({gnt0, gnt1, done0, done1, busy, q}), 16'(model_out()));
        chk("gnt_onehot", 16'(gnt0 & gnt1), 16'd0);
        chk("done_onehot", 16'(done0 & done1), 16'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        tick("reset");
        rst = 1'b0;
    endtask

    // Hold req1 with the given limit; expect exp_cnt grant cycles ending at q=lim.
    task automatic run_req1(input logic [WIDTH-1:0] lim, input int exp_cnt, input string nm);
        int n, cnt;
        logic [WIDTH-1:0] last_q;
        req1 = 1'b1; limit1 = lim;
        n = 0;
        while (!gnt1 && n < 10) begin tick(nm); n++; end
        chk({nm, "_granted"}, 16'(gnt1), 16'd1);
        chk({nm, "_q0"}, 16'(q), 16'd0);
        cnt = 1; last_q = q; n = 0;
        while (gnt1 && n < 40) begin
            limit1 = 4'($urandom_range(0, 15));
            tick(nm);
            if (gnt1) begin cnt++; last_q = q; end
            n++;
        end
        chk({nm, "_gnt_cycles"}, 16'(cnt), 16'(exp_cnt));
        chk({nm, "_last_q"}, 16'(last_q), 16'(lim));
        chk({nm, "_done1"}, 16'({done1, q}), 16'({1'b1, lim}));
        req1 = 1'b0;
        tick(nm);
    endtask

    function automatic bit next_req(input bit cur, input bit g, input bit d);
        if (d)       return ($urandom_range(0, 9) < 2);
        if (g)       return ($urandom_range(0, 99) < 97);
        if (cur)     return ($urandom_range(0, 99) < 95);
        return ($urandom_range(0, 99) < 25);
    endfunction

    typedef struct {
        logic             rst;
        logic             r0;
        logic [WIDTH-1:0] l0;
        logic             g0;
        logic             d0;
        logic             b;
        logic [WIDTH-1:0] qv;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic r0, input logic [WIDTH-1:0] l0,
                                input logic g0, input logic d0, input logic b,
                                input logic [WIDTH-1:0] qv);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.l0 = l0; v.g0 = g0; v.d0 = d0; v.b = b; v.qv = qv;
        return v;
    endfunction

    initial begin
        vec_t tv [13];
        int   order [$];
        int   n;
        logic pg0, pg1;

        // limit 3 run with mid-run limit changes, then abort on 3rd RUN cycle of a limit 7 run
        tv[0]  = mk(1, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 3, 1, 0, 1, 0);
        tv[2]  = mk(0, 1, 0, 1, 0, 1, 1);
        tv[3]  = mk(0, 1, 0, 1, 0, 1, 2);
        tv[4]  = mk(0, 1, 0, 1, 0, 1, 3);
        tv[5]  = mk(0, 1, 0, 0, 1, 1, 3);
        tv[6]  = mk(0, 0, 0, 0, 0, 0, 3);
        tv[7]  = mk(0, 0, 0, 0, 0, 0, 3);
        tv[8]  = mk(0, 1, 7, 1, 0, 1, 0);
        tv[9]  = mk(0, 1, 7, 1, 0, 1, 1);
        tv[10] = mk(0, 1, 7, 1, 0, 1, 2);
        tv[11] = mk(0, 0, 7, 0, 0, 0, 2);
        tv[12] = mk(0, 0, 7, 0, 0, 0, 2);
        foreach (tv[i]) begin
            rst = tv[i].rst; req0 = tv[i].r0; req1 = 1'b0; limit0 = tv[i].l0;
            tick("table_model");
            chk($sformatf("table_row%0d", i), 16'({gnt0, gnt1, done0, done1, busy, q}),
                16'({tv[i].g0, 1'b0, tv[i].d0, 1'b0, tv[i].b, tv[i].qv}));
        end

        // Both requesting from reset: grants alternate starting with req0
        reset_dut();
        req0 = 1'b1; req1 = 1'b1; limit0 = 4'd1; limit1 = 4'd2;
        pg0 = 1'b0; pg1 = 1'b0;
        for (int i = 0; i < 26; i++) begin
            tick("alternate");
            if (gnt0 && !pg0) order.push_back(0);
            if (gnt1 && !pg1) order.push_back(1);
            pg0 = gnt0; pg1 = gnt1;
        end
        chk("alt_count", 16'(order.size() >= 4), 16'd1);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk($sformatf("alt_order%0d", i), 16'(order[i]), 16'(i % 2));

        // Limit extremes for req1
        reset_dut();
        run_req1(4'd0, 1, "lim1_zero");
        reset_dut();
        run_req1(4'd15, 16, "lim1_max");

        // Reset mid-run at q=5, then both requesting: req0 wins first
        reset_dut();
        req0 = 1'b1; limit0 = 4'd9;
        n = 0;
        while (!(gnt0 && q == 4'd5) && n < 20) begin tick("rst_mid_run"); n++; end
        chk("rst_mid_reached_q5", 16'({gnt0, q}), 16'({1'b1, 4'd5}));
        rst = 1'b1; req1 = 1'b1;
        tick("rst_mid");
        chk("rst_mid_outputs", 16'({gnt0, gnt1, done0, done1, busy, q}), 16'd0);
        rst = 1'b0;
        tick("rst_first_grant");
        chk("rst_first_grant", 16'({gnt0, gnt1}), 16'b10);

        // req1 request-to-grant latency
        reset_dut();
        tick("lat_idle");
        tick("lat_idle");
        req1 = 1'b1; limit1 = 4'd2;
        n = 0;
        do begin tick("lat_wait"); n++; end while (!gnt1 && n < 8);
        chk("req1_latency", 16'(n), 16'(REQ1_LAT));

        // Randomized traffic against the model
        reset_dut();
        for (int i = 0; i < 2000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            req0   = next_req(req0, gnt0, done0);
            req1   = next_req(req1, gnt1, done1);
            limit0 = 4'($urandom_range(0, 15));
            limit1 = 4'($urandom_range(0, 15));
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
